// File: rtl/lu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lu_arb_pkg
// Description : Shared types and defaults for the load-increment issue arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lu_arb_pkg;

    localparam int         LU_PIPE_LAT   = 4;
    localparam logic [7:0] LU_DUMMY_ADDR = 8'hFF;
    localparam int         LU_TAG_IDW    = 2;

    typedef enum logic [1:0] {
        FLUSH   = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        DRAINED = 2'd3
    } lu_arb_state_e;

    // Completion tag layout for the default four-requester build.
    typedef struct packed {
        logic                  v;
        logic [LU_TAG_IDW-1:0] id;
        logic [7:0]            addr;
    } lu_tag_t;

    // Width of the {id, addr} payload carried alongside the valid bit.
    function automatic int lu_tag_payload_w(input int idw);
        return idw + 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lu_tag_delay.sv
`default_nettype none
// ============================================================================
// Module      : lu_tag_delay
// Description : DEPTH-entry tag shift register with async clear; exposes the
//               tail entry and whether any entry will be valid after this edge.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_tag_delay #(
    parameter int DEPTH = 5,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    input  logic [DW-1:0] in_data,
    output logic          out_v,
    output logic [DW-1:0] out_data,
    output logic          any_valid_next
);

    logic [DEPTH-1:0]         v_d;
    logic [DEPTH-1:0]         v_q;
    logic [DEPTH-1:0][DW-1:0] data_d;
    logic [DEPTH-1:0][DW-1:0] data_q;

    always_comb begin
        v_d    = {v_q[DEPTH-2:0], in_v};
        data_d = {data_q[DEPTH-2:0], in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign out_v          = v_q[DEPTH-1];
    assign out_data       = data_q[DEPTH-1];
    assign any_valid_next = |v_d;

endmodule
`default_nettype wire

// File: rtl/lu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lu_issue_arbiter
// Description : Round-robin issue arbiter for the load-increment-writeback
//               pipeline with flush, drain and completion tracking.
//               Optional LU_ARB_PERF_EN adds the idle_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_issue_arbiter
    import lu_arb_pkg::*;
#(
    parameter int         N          = 4,
    parameter int         IDW        = 2,
    parameter int         LAT        = LU_PIPE_LAT,
    parameter logic [7:0] DUMMY_ADDR = LU_DUMMY_ADDR
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*8-1:0] req_addr,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     icode,
    input  logic           drain_req,
    output logic           drain_done,
    output logic           busy,
    output logic           done_valid,
    output logic [IDW-1:0] done_id,
    output logic [7:0]     done_addr,
    output logic           addr_err
`ifdef LU_ARB_PERF_EN
    ,
    output logic [15:0]    idle_cnt
`endif
);

    localparam int DEPTH = LAT + 1;
    localparam int FCW   = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int PW    = lu_tag_payload_w(IDW);

    lu_arb_state_e  state_q;
    lu_arb_state_e  state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [FCW-1:0] flush_cnt_q;
    logic [FCW-1:0] flush_cnt_d;
    logic [7:0]     icode_q;
    logic [7:0]     icode_d;
    logic           drain_done_q;
    logic           drain_done_d;
    logic           busy_q;
    logic           busy_d;
    logic           addr_err_q;
    logic           addr_err_d;

    logic           grant_found;
    logic           grant_en;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   rr_idx;
    logic [7:0]     grant_addr;

    logic           tag_in_v;
    logic [PW-1:0]  tag_in_data;
    logic [PW-1:0]  tag_out_data;
    logic           any_valid_next;

    // Search from the pointer upward, wrapping past N-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (rr_idx >= (IDW+1)'(N)) begin
                rr_idx = rr_idx - (IDW+1)'(N);
            end
            if (!grant_found && req_valid[rr_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        grant_en   = (state_q == RUN) && !drain_req && grant_found;
        grant_addr = DUMMY_ADDR;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = grant_en && (grant_idx == IDW'(i));
            if (grant_idx == IDW'(i)) begin
                grant_addr = req_addr[i*8 +: 8];
            end
        end
    end

    // A request for the sink address still handshakes but never completes.
    always_comb begin
        tag_in_v    = grant_en && (grant_addr != DUMMY_ADDR);
        tag_in_data = tag_in_v ? {grant_idx, grant_addr} : '0;
    end

    lu_tag_delay #(
        .DEPTH (DEPTH),
        .DW    (PW)
    ) u_tag_delay (
        .clk            (clk),
        .rst            (rst),
        .in_v           (tag_in_v),
        .in_data        (tag_in_data),
        .out_v          (done_valid),
        .out_data       (tag_out_data),
        .any_valid_next (any_valid_next)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        flush_cnt_d  = flush_cnt_q;
        icode_d      = DUMMY_ADDR;
        addr_err_d   = 1'b0;
        drain_done_d = 1'b0;
        busy_d       = any_valid_next;

        if (grant_en) begin
            icode_d    = grant_addr;
            addr_err_d = (grant_addr == DUMMY_ADDR);
            ptr_d      = (grant_idx == IDW'(N-1)) ? '0 : grant_idx + IDW'(1);
        end

        case (state_q)
            FLUSH: begin
                if (flush_cnt_q == FCW'(LAT)) begin
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FCW'(1);
                end
            end
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!any_valid_next) begin
                    state_d      = DRAINED;
                    drain_done_d = 1'b1;
                end
            end
            DRAINED: begin
                if (drain_req) begin
                    drain_done_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FLUSH;
            ptr_q        <= '0;
            flush_cnt_q  <= '0;
            icode_q      <= DUMMY_ADDR;
            drain_done_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_cnt_q  <= flush_cnt_d;
            icode_q      <= icode_d;
            drain_done_q <= drain_done_d;
            busy_q       <= busy_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign icode      = icode_q;
    assign drain_done = drain_done_q;
    assign busy       = busy_q;
    assign addr_err   = addr_err_q;
    assign done_id    = tag_out_data[PW-1 -: IDW];
    assign done_addr  = tag_out_data[7:0];

`ifdef LU_ARB_PERF_EN
    logic [15:0] idle_cnt_q;
    logic [15:0] idle_cnt_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if ((state_q == RUN) && !grant_en && (idle_cnt_q != 16'hFFFF)) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign idle_cnt = idle_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lu_issue_arbiter
// Description : Directed scoreboard bench for lu_issue_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lu_issue_arbiter;
    import lu_arb_pkg::*;

    localparam int         N     = 4;
    localparam int         IDW   = 2;
    localparam int         LAT   = 4;
    localparam logic [7:0] DUMMY = 8'hFF;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_addr;
    logic [N-1:0]   req_ready;
    logic [7:0]     icode;
    logic           drain_req;
    logic           drain_done;
    logic           busy;
    logic           done_valid;
    logic [IDW-1:0] done_id;
    logic [7:0]     done_addr;
    logic           addr_err;
`ifdef LU_ARB_PERF_EN
    logic [15:0]    idle_cnt;
`endif

    typedef struct {
        int unsigned due;
        lu_tag_t     tag;
    } sb_item_t;

    sb_item_t    sb[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_icode = DUMMY;
    logic        exp_err = 1'b0;
    logic        exp_dd = 1'b0;

    always #5 clk = ~clk;

    lu_issue_arbiter #(
        .N   (N),
        .IDW (IDW),
        .LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .icode      (icode),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy       (busy),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_addr  (done_addr),
        .addr_err   (addr_err)
`ifdef LU_ARB_PERF_EN
        ,
        .idle_cnt   (idle_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [7:0] a);
        req_addr[8*i +: 8] = a;
    endtask

    // Mid-cycle check of all outputs, then record what this cycle's
    // handshakes must produce later.
    task automatic observe(input logic [N-1:0] exp_rdy);
        logic [N-1:0] hs;
        sb_item_t     it;
        @(negedge clk);
        cyc++;
        chk("req_ready", req_ready, exp_rdy);
        chk("icode", icode, exp_icode);
        chk("addr_err", addr_err, exp_err);
        chk("drain_done", drain_done, exp_dd);
        chk("busy", busy, sb.size() != 0);
        if (sb.size() != 0 && sb[0].due == cyc) begin
            it = sb.pop_front();
            chk("done_valid", done_valid, it.tag.v);
            chk("done_id", done_id, it.tag.id);
            chk("done_addr", done_addr, it.tag.addr);
        end else begin
            chk("no_done", done_valid, 1'b0);
        end
        hs        = req_valid & exp_rdy;
        exp_icode = DUMMY;
        exp_err   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                exp_icode = req_addr[8*i +: 8];
                if (exp_icode == DUMMY) begin
                    exp_err = 1'b1;
                end else begin
                    it.due      = cyc + LAT + 1;
                    it.tag.v    = 1'b1;
                    it.tag.id   = IDW'(i);
                    it.tag.addr = req_addr[8*i +: 8];
                    sb.push_back(it);
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] exp_rdy);
        observe(exp_rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        drain_req = 1'b0;
        req_addr  = '0;
        for (int i = 0; i < N; i++) begin
            set_addr(i, 8'(8'h20 + i));
        end
        req_valid = 4'hF;
        #1;

        // Reset state with every requester asking
        step(4'b0000);
        chk("rst_done_id", done_id, 2'd0);
        chk("rst_done_addr", done_addr, 8'h00);
        chk("rst_busy", busy, 1'b0);
        step(4'b0000);

        // Flush: five idle-issue cycles, then RR from id 0
        rst = 1'b0;
        repeat (5) step(4'b0000);
        step(4'b0001);
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        req_valid = 4'h0;
        repeat (6) step(4'b0000);

        // Single commit from requester 2
        set_addr(2, 8'h10);
        req_valid = 4'b0100;
        step(4'b0100);
        req_valid = 4'h0;
        repeat (6) step(4'b0000);

        // Drain with three ops in flight and requester 1 waiting
        req_valid = 4'b1001;
        step(4'b1000);
        step(4'b0001);
        step(4'b1000);
        req_valid = 4'b0010;
        drain_req = 1'b1;
        step(4'b0000);
        repeat (4) step(4'b0000);
        exp_dd = 1'b1;
        step(4'b0000);
        step(4'b0000);
        drain_req = 1'b0;
        step(4'b0000);
        exp_dd = 1'b0;
        step(4'b0010);
        req_valid = 4'h0;
        repeat (6) step(4'b0000);

        // Sink-address request from requester 3, then wrap to id 0
        set_addr(3, DUMMY);
        req_valid = 4'b1000;
        step(4'b1000);
        req_valid = 4'b1001;
        step(4'b0001);
        req_valid = 4'h0;
        repeat (6) step(4'b0000);
        set_addr(3, 8'h23);

        // Reset with four ops in flight
        req_valid = 4'hF;
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        rst = 1'b1;
        sb.delete();
        exp_icode = DUMMY;
        exp_err   = 1'b0;
`ifdef LU_ARB_PERF_EN
        chk("idle_cnt_rst", idle_cnt, 16'd0);
`endif
        step(4'b0000);
        step(4'b0000);
        rst = 1'b0;
        repeat (5) step(4'b0000);
        step(4'b0001);
`ifdef LU_ARB_PERF_EN
        chk("idle_cnt_grant", idle_cnt, 16'd0);
`endif
        req_valid = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            step(4'b0000);
`ifdef LU_ARB_PERF_EN
            chk("idle_cnt_run", idle_cnt, 32'(k));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lu_issue_arbiter.md
Name: lu_issue_arbiter

Overview:
- Shares the 5-stage load-increment-writeback pipeline (dual-port memory RMW, one op per clock) between N requesters.
- The pipeline has no valid bit and increments mem[ICODE] every cycle. This block therefore drives ICODE every cycle with either a granted address or a reserved dummy address.
- Round-robin grant, post-reset flush sequencing, drain control, and a completion tag pipe that reports which requester's write-back has committed.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester id width, equal to clog2(N).
- LAT, 4, cycles from ICODE presentation to write-back commit (S0→S3 + write port).
- DUMMY_ADDR, 8'hFF, reserved sink address; requesters must never use it.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N  per-requester request.
- req_addr  in  N*8  per-requester address; slice i is [8i+7:8i].
- req_ready  out  N  one-hot grant, combinational from state, pointer and req_valid.
- icode  out  8  registered address into the pipeline ICODE input.
- drain_req  in  1  level; stop granting and empty the pipe.
- drain_done  out  1  registered; high while drained and drain_req is held.
- busy  out  1  registered; high when any tag is in flight.
- done_valid  out  1  registered; 1-cycle commit pulse.
- done_id  out  IDW  requester id of the committed op.
- done_addr  out  8  address of the committed op.
- addr_err  out  1  registered; 1-cycle pulse when a granted address equals DUMMY_ADDR.

Behaviour:
- Reset values:
  - icode=DUMMY_ADDR; drain_done=0, busy=0, done_valid=0, done_id=0, done_addr=0, addr_err=0.
  - RR pointer=0; tag pipe cleared; state=FLUSH.
  - req_ready=0 while in reset.
- Handshake: a transfer occurs on a cycle with req_valid[i] & req_ready[i]. req_ready is never asserted without req_valid, and at most one bit is set.
- icode next value: the granted addr on a transfer, else DUMMY_ADDR. An address is therefore issued exactly one cycle after its handshake.
- Round-robin:
  - Grant the lowest index j >= ptr with req_valid[j], wrapping past N-1 to 0.
  - On a transfer, ptr <= (j+1) mod N. No transfer leaves ptr unchanged.
- States:
  - FLUSH: no grants; counts LAT+1 cycles issuing DUMMY_ADDR so reset-time pipeline contents retire. Then go to RUN.
  - RUN: grants per RR. If drain_req=1, go to DRAIN; no grant in that cycle, so drain wins over a simultaneous request.
  - DRAIN: no grants. When the tag pipe is empty (busy=0 next cycle), go to DRAINED.
  - DRAINED: drain_done=1. On drain_req=0, go to RUN with drain_done=0 the next cycle.
- Tag pipe:
  - A delay line of LAT+1 entries {v, id, addr}, entered on each transfer.
  - done_valid/id/addr are asserted exactly LAT+1 cycles after the handshake cycle (LAT=4: handshake in cycle 10 gives done in cycle 15).
  - busy = OR of all entry v bits.
- DUMMY_ADDR request:
  - The handshake completes and ptr advances.
  - icode carries DUMMY_ADDR; addr_err pulses the next cycle.
  - The tag enters with v=0, so no done_valid is produced for it.
- Same address back to back: allowed; pipeline forwarding resolves the hazard and no stall is inserted.
- Reset mid-operation: all in-flight tags are discarded, so no done pulses follow; the state returns to FLUSH.
- Throughput: one grant per cycle sustained in RUN.

Optional Feature:
- Macro: LU_ARB_PERF_EN.
- Defined: adds output port idle_cnt [15:0], reset to 0. It increments on each RUN cycle with no transfer, saturates at 16'hFFFF, and does not count in FLUSH, DRAIN or DRAINED.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package lu_arb_pkg holds:
  - the state enum {FLUSH, RUN, DRAIN, DRAINED};
  - localparam LU_PIPE_LAT=4 and LU_DUMMY_ADDR=8'hFF (parameter defaults);
  - typedef lu_tag_t {logic v; logic [IDW-1:0] id; logic [7:0] addr} for N=4.
- Sub-module lu_tag_delay: parameterized LAT+1 shift register with async clear. It outputs the tail entry and an any-valid flag.

Test Plan:
- Flush: reset released with all req_valid=1 → req_ready=0 and icode=8'hFF for 5 cycles, then the first grant goes to id 0.
- Round-robin: N=4, all valid continuously → grants 0,1,2,3,0 on consecutive cycles; icode follows each grant one cycle later; done_id follows 0,1,2,3 with done_valid LAT+1 cycles after each grant.
- Single commit: requester 2 only, addr 8'h10 at cycle 10 → icode=8'h10 in cycle 11, done_valid with id 2 and addr 8'h10 in cycle 15; a model memory read shows mem[8'h10] incremented by 1.
- Drain: drain_req=1 with requester 1 valid and 3 ops in flight → no grant that cycle; busy falls after the last done; drain_done=1; drain_req=0 → the next cycle grants requester 1.
- Error: requester 3 requests 8'hFF → handshake completes, addr_err pulses once, no done_valid; ptr wraps so the next grant goes to id 0.
- Reset mid-run: assert rst with 4 ops in flight → no done_valid after release; FLUSH repeats; with LU_ARB_PERF_EN, idle_cnt=0 after reset and counts idle RUN cycles.
